// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel: request/address out, ack/data back.
interface instr_fetch_if #(
  parameter int AW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [7:0]    imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// Fetch/sequence stage ahead of controlUnit: owns the PC, fetches instruction
// bytes (plus the immediate byte for IMM_OP), presents them during execute and
// applies taken branches when the datapath reports end of execute.
module instr_fetch #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]    IMM_OP   = 4'hC   // LOADIMM opcode
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master imem,
  output logic [4:0]    op_out,
  output logic [2:0]    operand,
  output logic [7:0]    imm,
  output logic          instr_valid,
  input  logic          pc_line,
  input  logic [AW-1:0] br_target,
  input  logic          exec_done,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {S_FETCH, S_FETCH_IMM, S_EXEC} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic [7:0]    imm_q, imm_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;

  // An ack only counts while our request is actually up; this also drops a
  // late ack arriving in the cycle right after reset.
  logic          ack_ok;
  assign ack_ok = req_q && imem.imem_ack;

  // Next-state logic for the fetch/execute sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    req_d   = req_q;
    valid_d = valid_q;
    case (state_q)
      S_FETCH: begin
        if (ack_ok) begin
          ir_d  = imem.imem_data;
          pc_d  = pc_q + 1'b1;
          req_d = 1'b0;
          if (imem.imem_data[7:4] == IMM_OP) begin
            state_d = S_FETCH_IMM;
          end else begin
            state_d = S_EXEC;
            valid_d = 1'b1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      S_FETCH_IMM: begin
        if (ack_ok) begin
          imm_d   = imem.imem_data;
          pc_d    = pc_q + 1'b1;
          req_d   = 1'b0;
          state_d = S_EXEC;
          valid_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      S_EXEC: begin
        // pc already points past the instruction; pc_line only matters here.
        if (exec_done) begin
          pc_d    = pc_line ? br_target : pc_q;
          req_d   = 1'b1;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset overrides any in-flight handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  // controlUnit sees NOP unless an instruction is executing.
  assign op_out      = valid_q ? ir_q[7:3] : 5'b0;
  assign operand     = ir_q[2:0];
  assign imm         = imm_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule
